// File: rtl/cache_fsm_l2_if.sv
// L1<->L2 and L2<->L3 handshake bundle for cache_fsm_l2.
// slave = the L2 controller's view; master = the surrounding L1/L3 environment.
interface cache_fsm_l2_if #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned BLOCK_WIDTH   = 128
);
  logic                     read_from_L2_request;
  logic                     write_to_L2_request;
  logic                     write_back_to_L2_request;
  logic [ADDRESS_WIDTH-1:0] cache_L2_memory_address;
  logic [DATA_WIDTH-1:0]    cache_write_data;
  logic [BLOCK_WIDTH-1:0]   write_back_to_L2_data;
  logic                     L2_ready;
  logic [BLOCK_WIDTH-1:0]   write_data_to_L1_from_L2;
  logic                     write_to_L2_verified;
  logic                     write_back_to_L2_verified;
  logic [ADDRESS_WIDTH-1:0] L3_memory_address;
  logic                     read_from_L3_request;
  logic                     write_back_to_L3_request;
  logic [BLOCK_WIDTH-1:0]   write_back_to_L3_data;
  logic                     L3_ready;
  logic [BLOCK_WIDTH-1:0]   write_data_to_L2_from_L3;
  logic                     write_back_to_L3_verified;

  modport slave (
    input  read_from_L2_request, write_to_L2_request, write_back_to_L2_request,
           cache_L2_memory_address, cache_write_data, write_back_to_L2_data,
           L3_ready, write_data_to_L2_from_L3, write_back_to_L3_verified,
    output L2_ready, write_data_to_L1_from_L2, write_to_L2_verified,
           write_back_to_L2_verified, L3_memory_address, read_from_L3_request,
           write_back_to_L3_request, write_back_to_L3_data
  );

  modport master (
    output read_from_L2_request, write_to_L2_request, write_back_to_L2_request,
           cache_L2_memory_address, cache_write_data, write_back_to_L2_data,
           L3_ready, write_data_to_L2_from_L3, write_back_to_L3_verified,
    input  L2_ready, write_data_to_L1_from_L2, write_to_L2_verified,
           write_back_to_L2_verified, L3_memory_address, read_from_L3_request,
           write_back_to_L3_request, write_back_to_L3_data
  );
endinterface

// File: rtl/cache_fsm_l2.sv
// Direct-mapped write-back/write-allocate L2 controller between the L1d FSM and L3.
// Optional hit/miss counters are built when L2_STATS_EN is defined.
module cache_fsm_l2 #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned BLOCK_WIDTH   = 128,
  parameter int unsigned L2_NUM_SETS   = 64
) (
  input  logic          clk,
  input  logic          reset_n,
`ifdef L2_STATS_EN
  output logic [31:0]   l2_hit_count,
  output logic [31:0]   l2_miss_count,
`endif
  cache_fsm_l2_if.slave bus
);
  localparam int unsigned WORDS   = BLOCK_WIDTH / DATA_WIDTH;
  localparam int unsigned OFF_W   = $clog2(WORDS);
  localparam int unsigned IDX_W   = $clog2(L2_NUM_SETS);
  localparam int unsigned IDX_LSB = 2 + OFF_W;
  localparam int unsigned TAG_LSB = IDX_LSB + IDX_W;
  localparam int unsigned PID_W   = 2;
  localparam int unsigned TAG_W   = ADDRESS_WIDTH - PID_W - TAG_LSB;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_LOOKUP     = 3'd1;
  localparam logic [2:0] S_WRITE_BACK = 3'd2;
  localparam logic [2:0] S_ALLOCATE   = 3'd3;
  localparam logic [2:0] S_RESPOND    = 3'd4;
  localparam logic [2:0] S_DRAIN      = 3'd5;

  localparam logic [1:0] K_READ  = 2'd0;
  localparam logic [1:0] K_WRITE = 2'd1;
  localparam logic [1:0] K_WBACK = 2'd2;

  logic [2:0]               state_q, state_d;
  logic [1:0]               kind_q, kind_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    word_q, word_d;
  logic [BLOCK_WIDTH-1:0]   blk_q, blk_d;
  logic [L2_NUM_SETS-1:0]   valid_q, valid_d;
  logic [L2_NUM_SETS-1:0]   dirty_q, dirty_d;

  logic                     l2_ready_q, l2_ready_d;
  logic [BLOCK_WIDTH-1:0]   rdata_q, rdata_d;
  logic                     wr_ver_q, wr_ver_d;
  logic                     wb_ver_q, wb_ver_d;
  logic [ADDRESS_WIDTH-1:0] l3_addr_q, l3_addr_d;
  logic                     rd_l3_q, rd_l3_d;
  logic                     wb_l3_q, wb_l3_d;
  logic [BLOCK_WIDTH-1:0]   wb_l3_data_q, wb_l3_data_d;

  logic [TAG_W-1:0]         tag_mem  [L2_NUM_SETS];
  logic [BLOCK_WIDTH-1:0]   data_mem [L2_NUM_SETS];
  logic                     mem_we;
  logic [BLOCK_WIDTH-1:0]   mem_wdata;

  logic [IDX_W-1:0]         idx;
  logic [TAG_W-1:0]         req_tag;
  logic [OFF_W-1:0]         off;
  logic [TAG_W-1:0]         line_tag;
  logic [BLOCK_WIDTH-1:0]   line_data;
  logic [BLOCK_WIDTH-1:0]   merged;
  logic                     hit;
  logic                     any_req;
  logic [ADDRESS_WIDTH-1:0] fetch_addr;
  logic [ADDRESS_WIDTH-1:0] victim_addr;
  logic                     unused_addr_bits;

  assign idx       = addr_q[IDX_LSB +: IDX_W];
  assign req_tag   = addr_q[TAG_LSB +: TAG_W];
  assign off       = addr_q[2 +: OFF_W];
  assign line_tag  = tag_mem[idx];
  assign line_data = data_mem[idx];
  assign hit       = valid_q[idx] && (line_tag == req_tag);
  assign any_req   = bus.read_from_L2_request | bus.write_to_L2_request |
                     bus.write_back_to_L2_request;
  assign unused_addr_bits = ^addr_q[1:0];

  // Processor-ID bits ride along on L3 addresses even though they are not part of the tag.
  assign fetch_addr  = {addr_q[ADDRESS_WIDTH-1:IDX_LSB], {IDX_LSB{1'b0}}};
  assign victim_addr = {addr_q[ADDRESS_WIDTH-1 -: PID_W], line_tag, idx, {IDX_LSB{1'b0}}};

  always_comb begin
    merged = line_data;
    merged[int'(off) * DATA_WIDTH +: DATA_WIDTH] = word_q;
  end

  always_comb begin
    state_d      = state_q;
    kind_d       = kind_q;
    addr_d       = addr_q;
    word_d       = word_q;
    blk_d        = blk_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    l2_ready_d   = 1'b0;
    wr_ver_d     = 1'b0;
    wb_ver_d     = 1'b0;
    rdata_d      = rdata_q;
    l3_addr_d    = l3_addr_q;
    rd_l3_d      = rd_l3_q;
    wb_l3_d      = wb_l3_q;
    wb_l3_data_d = wb_l3_data_q;
    mem_we       = 1'b0;
    mem_wdata    = blk_q;

    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          if (bus.write_back_to_L2_request)  kind_d = K_WBACK;
          else if (bus.write_to_L2_request)  kind_d = K_WRITE;
          else                               kind_d = K_READ;
          addr_d  = bus.cache_L2_memory_address;
          word_d  = bus.cache_write_data;
          blk_d   = bus.write_back_to_L2_data;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          state_d = S_RESPOND;
          case (kind_q)
            K_WBACK: begin
              mem_we       = 1'b1;
              mem_wdata    = blk_q;
              dirty_d[idx] = 1'b1;
              wb_ver_d     = 1'b1;
            end
            K_WRITE: begin
              mem_we       = 1'b1;
              mem_wdata    = merged;
              dirty_d[idx] = 1'b1;
              wr_ver_d     = 1'b1;
            end
            default: begin
              l2_ready_d = 1'b1;
              rdata_d    = line_data;
            end
          endcase
        end else if (valid_q[idx] && dirty_q[idx]) begin
          state_d      = S_WRITE_BACK;
          wb_l3_d      = 1'b1;
          l3_addr_d    = victim_addr;
          wb_l3_data_d = line_data;
        end else if (kind_q == K_WBACK) begin
          // A whole-block write-back needs no fetch: install it straight away.
          mem_we       = 1'b1;
          mem_wdata    = blk_q;
          valid_d[idx] = 1'b1;
          dirty_d[idx] = 1'b1;
          wb_ver_d     = 1'b1;
          state_d      = S_RESPOND;
        end else begin
          state_d   = S_ALLOCATE;
          rd_l3_d   = 1'b1;
          l3_addr_d = fetch_addr;
        end
      end
      S_WRITE_BACK: begin
        if (bus.write_back_to_L3_verified) begin
          wb_l3_d      = 1'b0;
          dirty_d[idx] = 1'b0;
          if (kind_q == K_WBACK) begin
            mem_we       = 1'b1;
            mem_wdata    = blk_q;
            valid_d[idx] = 1'b1;
            dirty_d[idx] = 1'b1;
            wb_ver_d     = 1'b1;
            state_d      = S_RESPOND;
          end else begin
            rd_l3_d   = 1'b1;
            l3_addr_d = fetch_addr;
            state_d   = S_ALLOCATE;
          end
        end
      end
      S_ALLOCATE: begin
        if (bus.L3_ready) begin
          rd_l3_d      = 1'b0;
          mem_we       = 1'b1;
          mem_wdata    = bus.write_data_to_L2_from_L3;
          valid_d[idx] = 1'b1;
          dirty_d[idx] = 1'b0;
          state_d      = S_LOOKUP;
        end
      end
      S_RESPOND: state_d = S_DRAIN;
      S_DRAIN: begin
        if (!any_req) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      kind_q       <= K_READ;
      addr_q       <= '0;
      word_q       <= '0;
      blk_q        <= '0;
      valid_q      <= '0;
      dirty_q      <= '0;
      l2_ready_q   <= 1'b0;
      rdata_q      <= '0;
      wr_ver_q     <= 1'b0;
      wb_ver_q     <= 1'b0;
      l3_addr_q    <= '0;
      rd_l3_q      <= 1'b0;
      wb_l3_q      <= 1'b0;
      wb_l3_data_q <= '0;
    end else begin
      state_q      <= state_d;
      kind_q       <= kind_d;
      addr_q       <= addr_d;
      word_q       <= word_d;
      blk_q        <= blk_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      l2_ready_q   <= l2_ready_d;
      rdata_q      <= rdata_d;
      wr_ver_q     <= wr_ver_d;
      wb_ver_q     <= wb_ver_d;
      l3_addr_q    <= l3_addr_d;
      rd_l3_q      <= rd_l3_d;
      wb_l3_q      <= wb_l3_d;
      wb_l3_data_q <= wb_l3_data_d;
    end
  end

  // Tag/data storage is qualified by valid_q, so it carries no reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      tag_mem[idx]  <= req_tag;
      data_mem[idx] <= mem_wdata;
    end
  end

  assign bus.L2_ready                  = l2_ready_q;
  assign bus.write_data_to_L1_from_L2  = rdata_q;
  assign bus.write_to_L2_verified      = wr_ver_q;
  assign bus.write_back_to_L2_verified = wb_ver_q;
  assign bus.L3_memory_address         = l3_addr_q;
  assign bus.read_from_L3_request      = rd_l3_q;
  assign bus.write_back_to_L3_request  = wb_l3_q;
  assign bus.write_back_to_L3_data     = wb_l3_data_q;

`ifdef L2_STATS_EN
  logic        first_q, first_d;
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  // Only the lookup entered from IDLE counts; the re-lookup after a fill does not.
  always_comb begin
    first_d    = first_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == S_IDLE && any_req) begin
      first_d = 1'b1;
    end else if (state_q == S_LOOKUP) begin
      first_d = 1'b0;
      if (first_q) begin
        if (hit) begin
          if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 32'd1;
        end else begin
          if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 32'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      first_q    <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      first_q    <= first_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign l2_hit_count  = hit_cnt_q;
  assign l2_miss_count = miss_cnt_q;
`else
  // Statistics counters absent in this build.
`endif

endmodule

// File: tb/tb_cache_fsm_l2.sv
// Self-checking bench for cache_fsm_l2: directed vector table, hand sequences, and
// randomized traffic checked against a memory-level reference model.
module tb_cache_fsm_l2;
  localparam logic [1:0] RD = 2'd0;
  localparam logic [1:0] WR = 2'd1;
  localparam logic [1:0] WB = 2'd2;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  cache_fsm_l2_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .BLOCK_WIDTH(128)) bus ();

`ifdef L2_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  cache_fsm_l2 #(
    .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .BLOCK_WIDTH(128), .L2_NUM_SETS(64)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
`ifdef L2_STATS_EN
    .l2_hit_count(hit_count),
    .l2_miss_count(miss_count),
`endif
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;
  int l3_lat = 3;
  int l3_reads = 0;
  int l3_wbs = 0;
  logic [31:0] last_wb_addr = '0;

  // Reference: per-set {valid, tag, dirty} plus the architecturally visible memory image.
  bit          mvalid [64];
  bit          mdirty [64];
  logic [19:0] mtag   [64];
  logic [127:0] golden [logic [25:0]];
  logic [127:0] l3mem  [logic [25:0]];

  function automatic logic [127:0] seed_blk(input logic [25:0] k);
    return {4{6'h2A, k}};
  endfunction

  function automatic logic [127:0] l3_get(input logic [25:0] k);
    if (l3mem.exists(k)) return l3mem[k];
    return seed_blk(k);
  endfunction

  function automatic logic [127:0] golden_get(input logic [25:0] k);
    if (golden.exists(k)) return golden[k];
    return seed_blk(k);
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void model_reset();
    foreach (mvalid[i]) begin
      mvalid[i] = 1'b0;
      mdirty[i] = 1'b0;
    end
    golden = l3mem;
  endfunction

  function automatic void model_predict(input logic [1:0] kind, input logic [31:0] addr,
                                        input int lat, output int exp_lat, output bit fetch,
                                        output bit evict, output logic [31:0] wbaddr,
                                        output logic [127:0] data);
    int s;
    bit hit;
    s = int'(addr[9:4]);
    hit = mvalid[s] && (mtag[s] == addr[29:10]);
    evict = !hit && mvalid[s] && mdirty[s];
    fetch = !hit && (kind != WB);
    wbaddr = {addr[31:30], mtag[s], addr[9:4], 4'h0};
    data = golden_get(addr[29:4]);
    if (hit) exp_lat = 2;
    else if (kind == WB) exp_lat = evict ? 3 + lat : 2;
    else exp_lat = evict ? 5 + 2 * lat : 4 + lat;
  endfunction

  function automatic void model_commit(input logic [1:0] kind, input logic [31:0] addr,
                                       input logic [31:0] word, input logic [127:0] blk);
    int s;
    bit hit;
    logic [127:0] b;
    s = int'(addr[9:4]);
    hit = mvalid[s] && (mtag[s] == addr[29:10]);
    if (kind == RD) mdirty[s] = hit ? mdirty[s] : 1'b0;
    else mdirty[s] = 1'b1;
    mvalid[s] = 1'b1;
    mtag[s] = addr[29:10];
    if (kind == WR) begin
      b = golden_get(addr[29:4]);
      b[int'(addr[3:2]) * 32 +: 32] = word;
      golden[addr[29:4]] = b;
    end else if (kind == WB) begin
      golden[addr[29:4]] = blk;
    end
  endfunction

  task automatic drop_all();
    bus.read_from_L2_request = 1'b0;
    bus.write_to_L2_request = 1'b0;
    bus.write_back_to_L2_request = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string nm);
    chk({nm, "_ctrl"}, {bus.L2_ready, bus.write_to_L2_verified, bus.write_back_to_L2_verified,
                        bus.read_from_L3_request, bus.write_back_to_L3_request}, '0);
    chk({nm, "_l1_data"}, bus.write_data_to_L1_from_L2, '0);
    chk({nm, "_l3_addr"}, bus.L3_memory_address, '0);
    chk({nm, "_l3_data"}, bus.write_back_to_L3_data, '0);
  endtask

  task automatic do_req(input string nm, input logic [1:0] kind, input logic [31:0] addr,
                        input logic [31:0] word, input logic [127:0] blk, input int exp_lat,
                        input bit exp_fetch, input bit exp_evict, input logic [31:0] exp_wbaddr,
                        input logic [127:0] exp_data);
    int n;
    bit seen;
    int rd0;
    int wb0;
    logic [2:0] pv;
    logic [2:0] exp_pv;
    rd0 = l3_reads;
    wb0 = l3_wbs;
    n = 0;
    seen = 1'b0;
    pv = '0;
    exp_pv = (kind == RD) ? 3'b100 : (kind == WR) ? 3'b010 : 3'b001;
    bus.cache_L2_memory_address = addr;
    bus.cache_write_data = word;
    bus.write_back_to_L2_data = blk;
    bus.read_from_L2_request = (kind == RD);
    bus.write_to_L2_request = (kind == WR);
    bus.write_back_to_L2_request = (kind == WB);
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      pv = {bus.L2_ready, bus.write_to_L2_verified, bus.write_back_to_L2_verified};
      if (pv != 3'b000) seen = 1'b1;
    end
    drop_all();
    chk({nm, "_pulse"}, pv, exp_pv);
    chk({nm, "_latency"}, n, exp_lat);
    chk({nm, "_l3_fetches"}, l3_reads - rd0, int'(exp_fetch));
    chk({nm, "_l3_evictions"}, l3_wbs - wb0, int'(exp_evict));
    if (exp_evict) chk({nm, "_evict_addr"}, last_wb_addr, exp_wbaddr);
    if (kind == RD) chk({nm, "_rdata"}, bus.write_data_to_L1_from_L2, exp_data);
    @(negedge clk);
    chk({nm, "_pulse_width"}, {bus.L2_ready, bus.write_to_L2_verified,
                               bus.write_back_to_L2_verified}, '0);
    @(negedge clk);
  endtask

  // L3 / main-memory responder.
  initial begin
    int cnt;
    logic [25:0] k;
    cnt = 0;
    bus.L3_ready = 1'b0;
    bus.write_back_to_L3_verified = 1'b0;
    bus.write_data_to_L2_from_L3 = '0;
    forever begin
      @(negedge clk);
      bus.L3_ready = 1'b0;
      bus.write_back_to_L3_verified = 1'b0;
      k = bus.L3_memory_address[29:4];
      if (reset_n !== 1'b1) begin
        cnt = 0;
      end else if (bus.read_from_L3_request) begin
        if (cnt >= l3_lat) begin
          bus.write_data_to_L2_from_L3 = l3_get(k);
          bus.L3_ready = 1'b1;
          l3_reads++;
          cnt = 0;
        end else cnt++;
      end else if (bus.write_back_to_L3_request) begin
        if (cnt >= l3_lat) begin
          chk("l3_evicted_data", bus.write_back_to_L3_data, golden_get(k));
          l3mem[k] = bus.write_back_to_L3_data;
          last_wb_addr = bus.L3_memory_address;
          bus.write_back_to_L3_verified = 1'b1;
          l3_wbs++;
          cnt = 0;
        end else cnt++;
      end else begin
        cnt = 0;
      end
    end
  end

  typedef struct {
    logic [1:0]   kind;
    logic [31:0]  addr;
    logic [31:0]  word;
    logic [127:0] blk;
    int           lat;
    bit           fetch;
    bit           evict;
    logic [31:0]  wbaddr;
    logic [127:0] data;
  } vec_t;

  vec_t vt [5];

  initial begin
    int exp_lat;
    bit fetch;
    bit evict;
    logic [31:0] wbaddr;
    logic [127:0] data;
    logic [1:0] kind;
    logic [31:0] addr;
    logic [31:0] word;
    logic [127:0] blk;
    int pulses;
    int n;
    logic [2:0] pv;

    vt[0] = '{RD, 32'hC000_0040, 32'h0, '0, 7, 1'b1, 1'b0, 32'h0, 128'hA5};
    vt[1] = '{RD, 32'hC000_0040, 32'h0, '0, 2, 1'b0, 1'b0, 32'h0, 128'hA5};
    vt[2] = '{WR, 32'hC000_0048, 32'hDEAD_BEEF, '0, 2, 1'b0, 1'b0, 32'h0, '0};
    vt[3] = '{RD, 32'hC000_0040, 32'h0, '0, 2, 1'b0, 1'b0, 32'h0,
              128'h00000000_DEADBEEF_00000000_000000A5};
    vt[4] = '{RD, 32'hC000_1040, 32'h0, '0, 11, 1'b1, 1'b1, 32'hC000_0040, 128'h1040};

    l3mem[26'h000_0004] = 128'hA5;
    l3mem[26'h000_0104] = 128'h1040;

    reset_n = 1'b0;
    drop_all();
    bus.cache_L2_memory_address = '0;
    bus.cache_write_data = '0;
    bus.write_back_to_L2_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);

    l3_lat = 3;
    foreach (vt[i]) begin
      do_req($sformatf("vec%0d", i), vt[i].kind, vt[i].addr, vt[i].word, vt[i].blk,
             vt[i].lat, vt[i].fetch, vt[i].evict, vt[i].wbaddr, vt[i].data);
      model_commit(vt[i].kind, vt[i].addr, vt[i].word, vt[i].blk);
    end
    chk("evicted_block_in_l3", l3_get(26'h000_0004), 128'h00000000_DEADBEEF_00000000_000000A5);

    // Write-back and read together: write-back wins, held read is not re-serviced.
    bus.cache_L2_memory_address = 32'h0000_2050;
    bus.write_back_to_L2_data = 128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978;
    bus.write_back_to_L2_request = 1'b1;
    bus.read_from_L2_request = 1'b1;
    n = 0;
    pv = '0;
    while (pv == 3'b000 && n < 50) begin
      @(negedge clk);
      n++;
      pv = {bus.L2_ready, bus.write_to_L2_verified, bus.write_back_to_L2_verified};
    end
    bus.write_back_to_L2_request = 1'b0;
    chk("prio_pulse", pv, 3'b001);
    chk("prio_latency", n, 2);
    model_commit(WB, 32'h0000_2050, 32'h0, 128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978);
    pulses = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.L2_ready) pulses++;
    end
    chk("held_read_not_serviced", pulses, 0);
    drop_all();
    repeat (2) @(negedge clk);
    model_predict(RD, 32'h0000_2050, l3_lat, exp_lat, fetch, evict, wbaddr, data);
    do_req("prio_reread", RD, 32'h0000_2050, 32'h0, '0, exp_lat, fetch, evict, wbaddr, data);
    model_commit(RD, 32'h0000_2050, 32'h0, '0);

    // Randomized traffic over a few conflicting sets.
    for (int t = 0; t < 80; t++) begin
      kind = 2'($urandom_range(0, 2));
      addr = {2'($urandom_range(0, 3)), 20'($urandom_range(0, 2)),
              6'(4 + $urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'b00};
      word = $urandom;
      blk = {$urandom, $urandom, $urandom, $urandom};
      l3_lat = int'($urandom_range(0, 4));
      model_predict(kind, addr, l3_lat, exp_lat, fetch, evict, wbaddr, data);
      do_req($sformatf("rand%0d", t), kind, addr, word, blk, exp_lat, fetch, evict, wbaddr, data);
      model_commit(kind, addr, word, blk);
    end

    // Reset while a fill is outstanding: outputs clear, no response, cache state lost.
    l3_lat = 20;
    bus.cache_L2_memory_address = 32'hC000_0140;
    bus.read_from_L2_request = 1'b1;
    repeat (4) @(negedge clk);
    chk("fill_outstanding", bus.read_from_L3_request, 1'b1);
    reset_n = 1'b0;
    drop_all();
    #1;
    chk_outputs_zero("reset_mid_alloc");
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.L2_ready | bus.read_from_L3_request) pulses++;
    end
    chk("no_activity_in_reset", pulses, 0);
    reset_n = 1'b1;
    model_reset();
    @(negedge clk);
    l3_lat = 3;
    model_predict(RD, 32'hC000_0040, l3_lat, exp_lat, fetch, evict, wbaddr, data);
    do_req("post_reset_read", RD, 32'hC000_0040, 32'h0, '0, exp_lat, fetch, evict, wbaddr, data);
    model_commit(RD, 32'hC000_0040, 32'h0, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/cache_fsm_l2.md
Name: cache_fsm_L2

Overview:
- Unified L2 cache controller directly downstream of the L1d FSM; it services the L1d's block reads, word write-throughs (inclusion) and dirty-block write-backs.
- Direct-mapped, write-back, write-allocate, one block per set.
- Misses and dirty evictions go to the L3/main-memory port over a request/verify handshake.
- One transaction in flight at a time.

Parameters:
ADDRESS_WIDTH, 32, request address width; bits [31:30] are the processor ID and are excluded from the tag
DATA_WIDTH, 32, word width of L1 write-through data
BLOCK_WIDTH, 128, block width; equals MAIN_MEMORY_DATA_WIDTH
L2_NUM_SETS, 64, number of sets; power of two

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
read_from_L2_request  input  1  L1 block read request, held until L2_ready
write_to_L2_request  input  1  L1 word write-through, held until write_to_L2_verified
write_back_to_L2_request  input  1  L1 dirty-block write-back, held until write_back_to_L2_verified
cache_L2_memory_address  input  ADDRESS_WIDTH  request address
cache_write_data  input  DATA_WIDTH  word for write-through
write_back_to_L2_data  input  BLOCK_WIDTH  block for write-back
L2_ready  output  1  one-cycle pulse: read data valid
write_data_to_L1_from_L2  output  BLOCK_WIDTH  block returned to L1; held until the next read response
write_to_L2_verified  output  1  one-cycle pulse
write_back_to_L2_verified  output  1  one-cycle pulse
L3_memory_address  output  ADDRESS_WIDTH  block-aligned address to L3
read_from_L3_request  output  1  fetch request, level, held until L3_ready
write_back_to_L3_request  output  1  eviction request, level, held until write_back_to_L3_verified
write_back_to_L3_data  output  BLOCK_WIDTH  evicted block
L3_ready  input  1  fetch data valid, single cycle
write_data_to_L2_from_L3  input  BLOCK_WIDTH  fetched block
write_back_to_L3_verified  input  1  eviction accepted, single cycle

Behaviour:
- Address split:
  - offset = [3:2] (word in block)
  - index = next log2(L2_NUM_SETS) bits, starting at bit 4
  - tag = bits above index up to bit 29
- Reset, asynchronous, while reset_n=0:
  - all outputs 0; valid and dirty arrays cleared; state IDLE
  - any in-flight transaction is abandoned, with no response pulse
  - tag and data arrays need not be cleared
- States: IDLE, LOOKUP, WRITE_BACK, ALLOCATE, RESPOND, DRAIN.
- IDLE:
  - if any request is high, latch type, address, word and block at the clock edge, then go to LOOKUP
  - priority when several requests are high: write_back > write > read
- LOOKUP (1 cycle):
  - hit = valid[index] && tag match
  - write-back hit: replace block, set dirty -> RESPOND
  - write hit: merge word at offset, set dirty -> RESPOND
  - read hit -> RESPOND
  - miss with victim valid and dirty -> WRITE_BACK
  - miss otherwise -> ALLOCATE for read or write; write-back miss installs block directly (no fetch), sets valid and dirty -> RESPOND
- WRITE_BACK:
  - hold write_back_to_L3_request with the victim address {victim tag, index, 4'b0} and the victim data
  - on write_back_to_L3_verified: clear dirty, drop request
  - next state: ALLOCATE, or for an L1 write-back miss, install the block -> RESPOND
- ALLOCATE:
  - hold read_from_L3_request with the block-aligned request address
  - on L3_ready: install block, set valid, clear dirty, drop request
  - then re-enter LOOKUP, which now hits
- RESPOND (1 cycle):
  - pulse exactly one response matching the latched type
  - for a read, drive write_data_to_L1_from_L2 = block
- DRAIN:
  - wait until all three L1 requests are low, then go to IDLE
  - prevents double-servicing a held request
- Latency, counted from the cycle a request is first sampled in IDLE as cycle 0:
  - hit: response pulse in cycle 2
  - clean miss: 3 + L3 read latency + 1
  - dirty miss: additionally includes the eviction handshake
- All outputs are registered.
- L3 responses that arrive outside their waiting state are ignored.

Optional Feature:
- Macro: L2_STATS_EN.
- Defined:
  - adds outputs l2_hit_count[31:0] and l2_miss_count[31:0]
  - each increments once per first LOOKUP of a transaction (re-lookup after ALLOCATE not counted)
  - saturate at 32'hFFFF_FFFF; cleared by reset
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset, read 0xC000_0040 -> ALLOCATE; L3 returns 128'hA5 after 3 cycles -> L2_ready pulse with data 128'hA5, dirty=0.
- Read 0xC000_0040 again -> L2_ready in cycle 2, no L3 request.
- Write 32'hDEAD_BEEF to 0xC000_0048 (hit) -> write_to_L2_verified in cycle 2; next read returns word 2 = DEAD_BEEF.
- Read 0xC000_1040 (same index, new tag) -> write_back_to_L3_request addr 0xC000_0040 with the dirty block, then fetch, then L2_ready.
- Write-back and read asserted together -> write-back serviced first; read serviced only after requests drop and re-assert.
- Assert reset_n=0 during ALLOCATE -> all outputs 0; prior hit address now misses.
